// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the fetch FSM encoding, the IF/ID bundle and the PC helper.
package if_fetch_stage_pkg;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_FETCH = 2'd0,
        FS_HOLD  = 2'd1,
        FS_DRAIN = 2'd2
    } fstate_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } if_id_t;

    // Word-aligned increment; wraps modulo 2^32.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return {pc[31:2] + 30'd1, 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: hold, flush-to-NOP and async reset.
// Flush only replaces the instruction; the pc4 field keeps its value.
module if_id_reg
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    // Flush beats load; neither means hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q.instr <= NOP_INSTR;
            q.pc4   <= '0;
        end else if (flush) begin
            q.instr <= NOP_INSTR;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with req/ack imem handshake and IF/ID register.
// Redirect beats stall beats ack; an issued request is always drained.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] if_instr,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4
);

    fstate_t     state;
    fstate_t     state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic [31:0] req_addr;
    logic [31:0] req_nxt;
    logic [31:0] hold_word;
    logic [31:0] hold_nxt;
    logic [31:0] target;
    logic [31:0] pc_inc;
    logic        ld;
    logic        fl;
    if_id_t      ifid_d;
    if_id_t      ifid_q;

    assign target = {redirect_pc[31:2], 2'b00};
    assign pc_inc = pc_plus4(pc);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FS_FETCH;
        else     state <= state_nxt;
    end

    // Next-state: redirect, then stall, then ack.
    always_comb begin
        state_nxt = state;
        case (state)
            FS_FETCH: begin
                if (redirect)
                    state_nxt = imem_ack ? FS_FETCH : FS_DRAIN;
                else if (stall && imem_ack)
                    state_nxt = FS_HOLD;
            end
            FS_HOLD: begin
                if (redirect || !stall)
                    state_nxt = FS_FETCH;
            end
            FS_DRAIN: begin
                if (imem_ack)
                    state_nxt = FS_FETCH;
            end
            default: state_nxt = FS_FETCH;
        endcase
    end

    // Outputs and datapath next values per state.
    always_comb begin
        imem_req = 1'b1;
        if_instr = NOP_INSTR;
        ld       = 1'b0;
        fl       = 1'b0;
        ifid_d   = '{instr: imem_rdata, pc4: pc_inc};
        pc_nxt   = pc;
        req_nxt  = req_addr;
        hold_nxt = hold_word;
        case (state)
            FS_FETCH: begin
                if (imem_ack && !redirect)
                    if_instr = imem_rdata;
                if (redirect) begin
                    pc_nxt = target;
                    fl     = 1'b1;
                    if (imem_ack)
                        req_nxt = target;
                end else if (stall) begin
                    if (imem_ack)
                        hold_nxt = imem_rdata;
                end else if (imem_ack) begin
                    ld      = 1'b1;
                    pc_nxt  = pc_inc;
                    req_nxt = pc_inc;
                end else begin
                    fl = 1'b1;
                end
            end
            FS_HOLD: begin
                imem_req = 1'b0;
                if_instr = hold_word;
                ifid_d   = '{instr: hold_word, pc4: pc_inc};
                if (redirect) begin
                    pc_nxt  = target;
                    req_nxt = target;
                    fl      = 1'b1;
                end else if (!stall) begin
                    ld      = 1'b1;
                    pc_nxt  = pc_inc;
                    req_nxt = pc_inc;
                end
            end
            FS_DRAIN: begin
                if (redirect)
                    pc_nxt = target;
                if (redirect || !stall)
                    fl = 1'b1;
                if (imem_ack)
                    req_nxt = redirect ? target : pc;
            end
            default: begin
                imem_req = 1'b0;
            end
        endcase
    end

    // PC, request address and the stalled-response buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= {RESET_PC[31:2], 2'b00};
            req_addr  <= {RESET_PC[31:2], 2'b00};
            hold_word <= '0;
        end else begin
            pc        <= pc_nxt;
            req_addr  <= req_nxt;
            hold_word <= hold_nxt;
        end
    end

    assign imem_addr = req_addr;

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk   (clk),
        .rst   (rst),
        .load  (ld),
        .flush (fl),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign id_instr = ifid_q.instr;
    assign id_pc4   = ifid_q.pc4;

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS pipeline.
- Holds the PC and fetches over a req/ack instruction-memory handshake that may take one or more cycles.
- Presents the fetched word as a lookahead `if_instr` and the registered decode word `id_instr` to the ID-stage control unit.
- Obeys the ID-stage load-use stall and branch/jump redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, bubble word injected into IF/ID (sll $0,$0,0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  fetch byte address; stable while imem_req=1
imem_ack  in  1  response valid; imem_rdata sampled this cycle
imem_rdata  in  32  fetched instruction
stall  in  1  ID load-use stall (control unit cu_wpcir); 1 = hold PC and IF/ID
redirect  in  1  ID taken branch/jump/jr/jal (control unit cu_branch)
redirect_pc  in  32  target address, valid when redirect=1
if_instr  out  32  combinational lookahead: word that enters ID at next non-stalled edge, else NOP_INSTR
id_instr  out  32  IF/ID register: instruction in decode
id_pc4  out  32  IF/ID register: address of id_instr + 4

Behaviour:
Reset (async):
- pc=RESET_PC, req_addr=RESET_PC, state=FETCH.
- id_instr=NOP_INSTR, id_pc4=0, buf=0.
- imem_req=1 on the first cycle after reset release.

State machine (2-bit): FETCH, HOLD, DRAIN.

FETCH:
- imem_req=1, imem_addr=req_addr (=pc).
- Priority: redirect > stall > ack.
- redirect=1:
  - pc<=redirect_pc; id_instr<=NOP_INSTR (branch shadow squashed, no delay slot); id_pc4 unchanged.
  - If ack this cycle: response discarded, req_addr<=redirect_pc, stay FETCH.
  - If no ack: go DRAIN; req_addr keeps the old address.
- stall=1 (no redirect):
  - id_instr/id_pc4 hold.
  - If ack: buf<=imem_rdata, go HOLD; pc unchanged.
  - No ack: stay FETCH.
- ack (no stall, no redirect): id_instr<=imem_rdata, id_pc4<=pc+4, pc<=pc+4, req_addr<=pc+4. Back-to-back acks give 1 instr/cycle.
- No ack (no stall, no redirect): id_instr<=NOP_INSTR (bubble), id_pc4 holds.

HOLD:
- imem_req=0; buffered word waits for the stall to clear.
- redirect=1: buf discarded, pc<=redirect_pc, req_addr<=redirect_pc, id_instr<=NOP_INSTR, go FETCH.
- stall=0: id_instr<=buf, id_pc4<=pc+4, pc<=pc+4, req_addr<=pc+4, go FETCH.
- stall=1: hold everything.

DRAIN:
- imem_req=1 with the old req_addr until ack; the response is discarded.
- id_instr<=NOP_INSTR each cycle unless stall=1.
- On ack: req_addr<=pc (the redirect target), go FETCH.
- A further redirect in DRAIN overwrites pc only.

if_instr (combinational):
- HOLD: buf.
- FETCH with ack and no redirect: imem_rdata.
- Otherwise: NOP_INSTR.

Arithmetic: pc+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0. pc[1:0] is forced to 0 on every load.

No request is ever abandoned. At most one request is outstanding.

Decomposition:
- Shared macro header additions: NOP_INSTR value and state encodings FS_FETCH=2'd0, FS_HOLD=2'd1, FS_DRAIN=2'd2.
- One sub-module, `if_id_reg`: the 64-bit IF/ID register with hold (stall), flush-to-NOP and async reset.

Test Plan:
1. Reset, single-cycle memory (ack=req), mem[0..12]=A,B,C,D -> imem_addr 0,4,8,12 on consecutive cycles; id_instr A,B,C with id_pc4 4,8,12.
2. 3-cycle ack latency -> two NOP bubbles between each id_instr; imem_addr held constant until ack.
3. stall=1 for 2 cycles while ack arrives at address 8 -> state HOLD, imem_req=0, id_instr held; if_instr=mem[8]; after stall drops, id_instr=mem[8], id_pc4=12, next fetch at 12.
4. redirect=1, redirect_pc=0x40, ack same cycle at address 8 -> id_instr=NOP; next imem_addr=0x40; mem[8] never reaches ID.
5. redirect to 0x80 while a 4-cycle fetch of 0x10 is outstanding -> addr 0x10 held to ack, response dropped, next request 0x80, no stray instruction in ID.
6. rst asserted mid-DRAIN (asynchronous) -> immediately pc=0, id_instr=NOP; first post-reset request at 0.
